// File: rtl/dog_sprite_fetch.sv
// Sprite fetch pipeline: hit test, ROM addressing, transparency tagging and animation frame stepping.
// Latency: pixel presented in cycle N yields rom_addr after edge N+1 and index/index_valid/opaque after edge N+3.
// Backpressure: none; fully streaming at one pixel per clock, no stall inputs.
module dog_sprite_fetch #(
  parameter int         SPRITE_W   = 32,
  parameter int         SPRITE_H   = 32,
  parameter int         FRAMES     = 4,
  parameter int         FRAME_DIV  = 8,
  parameter logic [3:0] TRANSP_IDX = 4'h1,
  parameter int         ADDR_W     = 12
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      vsync,
  input  logic                      pix_valid,
  input  logic [9:0]                draw_x,
  input  logic [9:0]                draw_y,
  input  logic [9:0]                dog_x,
  input  logic [9:0]                dog_y,
  input  logic                      anim_en,
  input  logic                      flip,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [3:0]                rom_q,
  output logic [3:0]                index,
  output logic                      index_valid,
  output logic                      opaque,
  output logic [$clog2(FRAMES)-1:0] frame
);

  localparam int CW = $clog2(SPRITE_W);
  localparam int RW = $clog2(SPRITE_H);
  localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

  // 11-bit copies so sprite extents past column/row 1023 never wrap back on screen
  logic [10:0] x11, y11, dogx11, dogy11;
  logic        hit;
  logic [CW-1:0] col_raw, col;
  logic [RW-1:0] row;
  logic [ADDR_W-1:0] addr_nxt;

  // pipeline bookkeeping travelling alongside the ROM access
  logic hit1, pv1, hit2, pv2;

  // animation state
  logic          vs_prev;
  logic          frame_evt;
  logic [DW-1:0] div;

  assign x11    = {1'b0, draw_x};
  assign y11    = {1'b0, draw_y};
  assign dogx11 = {1'b0, dog_x};
  assign dogy11 = {1'b0, dog_y};

  // stage 0: hit test and sprite-local coordinates, mirrored when flip is set
  always_comb begin
    hit = pix_valid
        && (x11 >= dogx11) && (x11 < dogx11 + 11'(SPRITE_W))
        && (y11 >= dogy11) && (y11 < dogy11 + 11'(SPRITE_H));
    col_raw = CW'(draw_x - dog_x);
    row     = RW'(draw_y - dog_y);
    col     = flip ? (CW'(SPRITE_W - 1) - col_raw) : col_raw;
    // power-of-two dimensions make frame*W*H + row*W + col a plain concatenation
    addr_nxt = hit ? ADDR_W'({frame, row, col}) : '0;
  end

  // stage 1: register ROM address with hit/valid; stage 2: align hit/valid with rom_q
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_addr <= '0;
      hit1     <= 1'b0;
      pv1      <= 1'b0;
      hit2     <= 1'b0;
      pv2      <= 1'b0;
    end else begin
      rom_addr <= addr_nxt;
      hit1     <= hit;
      pv1      <= pix_valid;
      hit2     <= hit1;
      pv2      <= pv1;
    end
  end

  // stage 3: palette index, visibility and transparency flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index       <= TRANSP_IDX;
      index_valid <= 1'b0;
      opaque      <= 1'b0;
    end else begin
      index       <= hit2 ? rom_q : TRANSP_IDX;
      index_valid <= pv2;
      opaque      <= hit2 && (rom_q != TRANSP_IDX);
    end
  end

  assign frame_evt = vs_prev & ~vsync;

  // vsync falling edge steps the divider; divider wrap advances the frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vs_prev <= 1'b0;
      div     <= '0;
      frame   <= '0;
    end else begin
      vs_prev <= vsync;
      if (!anim_en) begin
        div <= '0;
      end else if (frame_evt) begin
        if (div == DW'(FRAME_DIV - 1)) begin
          div   <= '0;
          frame <= frame + ($clog2(FRAMES))'(1);
        end else begin
          div <= div + DW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_dog_sprite_fetch.sv
// Bench for dog_sprite_fetch: ROM model plus arithmetic reference model with randomized and directed pixels.
// Latency: checks rom_addr one edge and outputs three edges after each presented pixel.
// Backpressure: none; one pixel presented per clock.
module tb_dog_sprite_fetch;

  localparam int         SW      = 32;
  localparam int         SH      = 32;
  localparam int         NFRM    = 4;
  localparam int         FDIV    = 8;
  localparam logic [3:0] TRANSP  = 4'h1;

  typedef struct {
    bit pv;
    bit hit;
    int addr;
    int idx;
    bit opq;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n, vsync, pix_valid, anim_en, flip;
  logic [9:0]  draw_x, draw_y, dog_x, dog_y;
  logic [11:0] rom_addr;
  logic [3:0]  rom_q, index;
  logic        index_valid, opaque;
  logic [1:0]  frame;

  logic [3:0]  mem [0:4095];
  exp_t        hist [3];
  int          checks = 0;
  int          errors = 0;
  int          m_frame, m_div, vcount;
  bit          m_vs_prev;

  always #5 clk = ~clk;

  // synchronous sprite ROM
  always @(posedge clk) rom_q <= mem[rom_addr];

  dog_sprite_fetch #(
    .SPRITE_W(SW), .SPRITE_H(SH), .FRAMES(NFRM), .FRAME_DIV(FDIV),
    .TRANSP_IDX(TRANSP), .ADDR_W(12)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vsync(vsync), .pix_valid(pix_valid),
    .draw_x(draw_x), .draw_y(draw_y), .dog_x(dog_x), .dog_y(dog_y),
    .anim_en(anim_en), .flip(flip), .rom_addr(rom_addr), .rom_q(rom_q),
    .index(index), .index_valid(index_valid), .opaque(opaque), .frame(frame)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // expected pipeline result for the pixel currently on the inputs
  function automatic exp_t model();
    exp_t e;
    int dx, dy, gx, gy, col, row;
    dx = int'(draw_x); dy = int'(draw_y);
    gx = int'(dog_x);  gy = int'(dog_y);
    e.pv  = pix_valid;
    e.hit = pix_valid && dx >= gx && dx < gx + SW && dy >= gy && dy < gy + SH;
    col = dx - gx;
    row = dy - gy;
    if (flip) col = SW - 1 - col;
    e.addr = e.hit ? (m_frame * SW * SH + row * SW + col) : 0;
    e.idx  = e.hit ? int'(mem[e.addr]) : int'(TRANSP);
    e.opq  = e.hit && (mem[e.addr] != TRANSP);
    return e;
  endfunction

  task automatic flush_model();
    for (int i = 0; i < 3; i++) hist[i] = '{pv: 0, hit: 0, addr: 0, idx: int'(TRANSP), opq: 0};
    m_frame   = 0;
    m_div     = 0;
    m_vs_prev = 0;
  endtask

  // one clock: predict, advance the animation model, then compare after the edge
  task automatic step();
    exp_t e;
    bit   evt;
    e = model();
    hist[2] = hist[1];
    hist[1] = hist[0];
    hist[0] = e;
    evt = m_vs_prev && !vsync;
    m_vs_prev = vsync;
    if (!anim_en) m_div = 0;
    else if (evt) begin
      m_div++;
      if (m_div == FDIV) begin
        m_div   = 0;
        m_frame = (m_frame + 1) % NFRM;
      end
    end
    @(posedge clk); #1;
    chk("rom_addr", rom_addr, e.addr);
    chk("index", index, hist[2].idx);
    chk("index_valid", index_valid, hist[2].pv);
    chk("opaque", opaque, hist[2].opq);
    chk("frame", frame, m_frame);
    if (index_valid === 1'b1) vcount++;
  endtask

  task automatic pix(input int x, input int y, input bit pv);
    draw_x    = 10'(x);
    draw_y    = 10'(y);
    pix_valid = pv;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) pix(0, 0, 0);
  endtask

  task automatic vs_edges(input int n);
    for (int i = 0; i < n; i++) begin
      vsync = 1'b0; pix(0, 0, 0);
      vsync = 1'b1; pix(0, 0, 0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rom_addr"}, rom_addr, 0);
    chk({tag, "_index"}, index, TRANSP);
    chk({tag, "_index_valid"}, index_valid, 0);
    chk({tag, "_opaque"}, opaque, 0);
    chk({tag, "_frame"}, frame, 0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 4'($urandom);
    reset_n = 1'b0; vsync = 1'b1; pix_valid = 1'b0; anim_en = 1'b0; flip = 1'b0;
    draw_x = '0; draw_y = '0; dog_x = '0; dog_y = '0;
    vcount = 0;
    flush_model();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("por");
    reset_n = 1'b1;

    // corner pixels, frame 0, no flip
    dog_x = 10'd100; dog_y = 10'd50;
    pix(100, 50, 1); chk("corner_first_addr", rom_addr, 0);
    pix(131, 81, 1); chk("corner_last_addr", rom_addr, 1023);
    pix(132, 50, 1); chk("right_miss_addr", rom_addr, 0);
    idle(3);
    for (int i = 0; i < 300; i++) begin
      flip = 1'($urandom);
      pix($urandom_range(140, 90), $urandom_range(90, 40), ($urandom % 4) != 0);
    end
    flip = 1'b0;
    idle(3);

    // animation: 8 falling edges per frame step
    anim_en = 1'b1;
    vs_edges(7);  chk("anim_7_edges", frame, 0);
    vs_edges(1);  chk("anim_8_edges", frame, 1);
    vs_edges(8);  chk("anim_16_edges", frame, 2);

    // mirrored fetch in frame 2
    flip = 1'b1;
    pix(100, 50, 1); chk("flip_left_addr", rom_addr, 2079);
    pix(131, 50, 1); chk("flip_right_addr", rom_addr, 2048);
    for (int i = 0; i < 100; i++) pix($urandom_range(135, 95), $urandom_range(85, 45), 1);
    flip = 1'b0;
    idle(3);
    vs_edges(8);  chk("anim_24_edges", frame, 3);
    vs_edges(8);  chk("anim_wrap_32", frame, 0);

    // disabling the animation clears the divider and holds the frame
    vs_edges(3);
    anim_en = 1'b0;
    vs_edges(8);  chk("anim_hold", frame, 0);
    anim_en = 1'b1;
    vs_edges(7);  chk("anim_div_cleared_7", frame, 0);
    vs_edges(1);  chk("anim_div_cleared_8", frame, 1);

    // right screen edge and wrap-free extents
    dog_x = 10'd620; dog_y = 10'd50;
    pix(639, 60, 1); chk("edge_hit_col19", rom_addr, 1024 + 10 * 32 + 19);
    pix(0, 60, 1);   chk("edge_x0_miss", rom_addr, 0);
    dog_x = 10'd1010;
    pix(0, 60, 1);   chk("wrap_x0_miss", rom_addr, 0);
    for (int i = 0; i < 150; i++) begin
      dog_x = 10'($urandom_range(1023, 600));
      dog_y = 10'($urandom_range(1023, 0));
      pix($urandom_range(1023, 0), $urandom_range(1023, 0), 1);
      pix(int'(dog_x) + $urandom_range(40, 0), int'(dog_y) + $urandom_range(40, 0), 1);
    end
    idle(3);

    // transparent then opaque on adjacent pixels
    dog_x = 10'd100; dog_y = 10'd50;
    mem[1024 + 5] = TRANSP;
    mem[1024 + 6] = 4'h4;
    pix(105, 50, 1);
    pix(106, 50, 1);
    pix(0, 0, 0); chk("transp_first", opaque, 0);
    pix(0, 0, 0); chk("transp_second", opaque, 1);
    chk("transp_second_idx", index, 4);
    idle(3);

    // back-to-back full line
    vcount = 0;
    for (int x = 0; x < 640; x++) pix(x, 60, 1);
    idle(3);
    chk("stream_valid_count", vcount, 640);

    // reset mid-sprite, released with vsync low
    vs_edges(3);
    pix(105, 55, 1);
    pix(106, 55, 1);
    reset_n = 1'b0;
    vsync   = 1'b0;
    #1;
    chk_reset_vals("mid_reset");
    flush_model();
    @(posedge clk);
    @(posedge clk);
    #1;
    chk_reset_vals("reset_hold");
    reset_n = 1'b1;
    pix(107, 55, 1);
    pix(108, 55, 1);
    pix(109, 55, 1);
    vsync = 1'b1;
    pix(0, 0, 0);
    vs_edges(7);  chk("post_reset_7_edges", frame, 0);
    vs_edges(1);  chk("post_reset_8_edges", frame, 1);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
